pipeline_controller: RTL and testbench

//  Sequences the 5-stage pipeline: owns the PC and the instruction-bus fetch FSM, and builds each cycle's
//  IF/ID payload (temp_storage::if_id). It also drives per-register enables, flushes and bubbles for
//  IF/ID, ID/EX, EX/MEM and MEM/WB from MEM-stage data-bus stalls, EX redirects and load-use hazards.

---
 rtl/pipeline_controller_pkg.sv | 33 +++
 rtl/pipeline_controller_if.sv | 23 ++
 rtl/pipeline_controller_fetch_sequencer.sv | 97 +++++++++
 rtl/pipeline_controller.sv | 95 +++++++++
 tb/tb_pipeline_controller.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_controller_pkg.sv
// Shared types for the pipeline controller: IF/ID payload, fetch FSM states
// and the per-stage-register control bundle.
package pipeline_controller_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic        inst_signal;
    logic [31:0] inst;
    logic [63:0] inst_pc;
  } if_id_t;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_HOLD = 2'd1,
    F_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic flush_if_id;
    logic bubble_id_ex;
    logic bubble_mem_wb;
  } hazard_ctrl_t;

  // Branch/jump targets are word aligned; the low two bits are ignored.
  function automatic logic [63:0] align_target(input logic [63:0] target);
    return {target[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Instruction-bus handshake between the fetch logic (master) and the bus (slave).
interface pipeline_controller_if;

  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok;
  logic [31:0] iresp_inst;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_ok,
    input  iresp_inst
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_ok,
    output iresp_inst
  );

endinterface

// File: rtl/pipeline_controller_fetch_sequencer.sv
// PC, instruction-fetch FSM, hold buffer for fetched-but-stalled words and the
// pending redirect target used while an orphaned fetch drains.
module fetch_sequencer
  import pipeline_controller_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redir,
  input  logic        accept,
  input  logic [63:0] target,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_inst,
  output if_id_t      if_id_next
);

  fetch_state_e state, state_next;
  logic [63:0]  pc, pc_next;
  logic [31:0]  hold_buf, hold_buf_next;
  logic [63:0]  pending, pending_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= F_REQ;
      pc       <= RESET_PC;
      hold_buf <= '0;
      pending  <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      hold_buf <= hold_buf_next;
      pending  <= pending_next;
    end
  end

  // The address stays at pc for the whole request, so it is stable until iresp_ok.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    hold_buf_next = hold_buf;
    pending_next  = pending;
    ireq_valid    = 1'b0;
    ireq_addr     = pc;
    if_id_next    = '{inst_signal: 1'b0, inst: 32'd0, inst_pc: pc};

    unique case (state)
      F_REQ: begin
        ireq_valid = rst_n;
        if (iresp_ok) begin
          if (redir) begin
            pc_next = target;
          end else if (accept) begin
            if_id_next = '{inst_signal: 1'b1, inst: iresp_inst, inst_pc: pc};
            pc_next    = pc + 64'd4;
          end else begin
            hold_buf_next = iresp_inst;
            state_next    = F_HOLD;
          end
        end else if (redir) begin
          pending_next = target;
          state_next   = F_KILL;
        end
      end

      F_HOLD: begin
        if (redir) begin
          pc_next    = target;
          state_next = F_REQ;
        end else if (accept) begin
          if_id_next = '{inst_signal: 1'b1, inst: hold_buf, inst_pc: pc};
          pc_next    = pc + 64'd4;
          state_next = F_REQ;
        end
      end

      F_KILL: begin
        // The response to the abandoned fetch is never delivered.
        ireq_valid = rst_n;
        if (redir) begin
          pending_next = target;
        end
        if (iresp_ok) begin
          pc_next    = redir ? target : pending;
          state_next = F_REQ;
        end
      end

      default: begin
        state_next = F_REQ;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencing: hazard detection driving stage-register enables,
// flushes and bubbles, plus the fetch sequencer and a stall-cycle counter.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_controller_if.master ibus,
  output if_id_t                if_id_next,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_redirect,
  input  logic [63:0]           ex_target,
  input  logic                  dreq_valid,
  input  logic                  dresp_ok,
  output logic                  en_if_id,
  output logic                  en_id_ex,
  output logic                  en_ex_mem,
  output logic                  flush_if_id,
  output logic                  bubble_id_ex,
  output logic                  bubble_mem_wb,
  output logic [31:0]           perf_stall_cnt
);

  logic         mem_stall;
  logic         redir;
  logic         load_use;
  logic         accept;
  hazard_ctrl_t ctrl;

  assign mem_stall = dreq_valid & ~dresp_ok;
  assign redir     = ex_redirect & ex_valid & ~mem_stall;
  assign load_use  = ex_valid & ex_is_load & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Priority: a stalled data bus freezes everything, then redirects, then load-use.
  always_comb begin
    ctrl = '{en_if_id: 1'b1, en_id_ex: 1'b1, en_ex_mem: 1'b1,
             flush_if_id: 1'b0, bubble_id_ex: 1'b0, bubble_mem_wb: 1'b0};
    if (!rst_n) begin
      ctrl = '{en_if_id: 1'b0, en_id_ex: 1'b0, en_ex_mem: 1'b0,
               flush_if_id: 1'b1, bubble_id_ex: 1'b1, bubble_mem_wb: 1'b1};
    end else if (mem_stall) begin
      ctrl.en_if_id      = 1'b0;
      ctrl.en_id_ex      = 1'b0;
      ctrl.en_ex_mem     = 1'b0;
      ctrl.bubble_mem_wb = 1'b1;
    end else if (redir) begin
      ctrl.flush_if_id  = 1'b1;
      ctrl.bubble_id_ex = 1'b1;
    end else if (load_use) begin
      ctrl.en_if_id     = 1'b0;
      ctrl.bubble_id_ex = 1'b1;
    end
  end

  assign en_if_id      = ctrl.en_if_id;
  assign en_id_ex      = ctrl.en_id_ex;
  assign en_ex_mem     = ctrl.en_ex_mem;
  assign flush_if_id   = ctrl.flush_if_id;
  assign bubble_id_ex  = ctrl.bubble_id_ex;
  assign bubble_mem_wb = ctrl.bubble_mem_wb;
  assign accept        = ctrl.en_if_id & ~redir;

  fetch_sequencer #(
    .RESET_PC (RESET_PC)
  ) u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .redir      (redir),
    .accept     (accept),
    .target     (align_target(ex_target)),
    .ireq_valid (ibus.ireq_valid),
    .ireq_addr  (ibus.ireq_addr),
    .iresp_ok   (ibus.iresp_ok),
    .iresp_inst (ibus.iresp_inst),
    .if_id_next (if_id_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
    end else if (!ctrl.en_if_id && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: fetch sequencing, hazards, redirects and reset.
module tb_pipeline_controller;
  import pipeline_controller_pkg::*;

  logic        clk;
  logic        rst_n;
  if_id_t      if_id_next;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_redirect;
  logic [63:0] ex_target;
  logic        dreq_valid, dresp_ok;
  logic        en_if_id, en_id_ex, en_ex_mem, flush_if_id, bubble_id_ex, bubble_mem_wb;
  logic [31:0] perf_stall_cnt;

  int total_checks;
  int bad_checks;

  pipeline_controller_if ibus ();

  pipeline_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ibus           (ibus),
    .if_id_next     (if_id_next),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_valid       (ex_valid),
    .ex_is_load     (ex_is_load),
    .ex_rd          (ex_rd),
    .ex_redirect    (ex_redirect),
    .ex_target      (ex_target),
    .dreq_valid     (dreq_valid),
    .dresp_ok       (dresp_ok),
    .en_if_id       (en_if_id),
    .en_id_ex       (en_id_ex),
    .en_ex_mem      (en_ex_mem),
    .flush_if_id    (flush_if_id),
    .bubble_id_ex   (bubble_id_ex),
    .bubble_mem_wb  (bubble_mem_wb),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge; checks follow #1 later.
  task automatic applyStimulus();
    @(negedge clk);
  endtask

  task automatic clearHazards();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
    ex_redirect = 1'b0; ex_target = 64'd0;
    dreq_valid = 1'b0; dresp_ok = 1'b0;
  endtask

  task automatic checkPayload(input string tag, input logic sig, input logic [31:0] inst,
                              input logic [63:0] pc);
    checkOutput({tag, ".sig"}, {63'd0, if_id_next.inst_signal}, {63'd0, sig});
    if (sig) checkOutput({tag, ".inst"}, {32'd0, if_id_next.inst}, {32'd0, inst});
    checkOutput({tag, ".pc"}, if_id_next.inst_pc, pc);
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    rst_n = 1'b0;
    clearHazards();
    ibus.iresp_ok   = 1'b0;
    ibus.iresp_inst = 32'd0;

    // 1: reset values, then back-to-back single-cycle fetches
    repeat (2) @(posedge clk);
    applyStimulus(); #1;
    checkOutput("rst.ireq_valid", {63'd0, ibus.ireq_valid}, 64'd0);
    checkOutput("rst.en_if_id", {63'd0, en_if_id}, 64'd0);
    checkOutput("rst.en_ex_mem", {63'd0, en_ex_mem}, 64'd0);
    checkOutput("rst.flush", {63'd0, flush_if_id}, 64'd1);
    checkOutput("rst.bubble_mem_wb", {63'd0, bubble_mem_wb}, 64'd1);
    checkOutput("rst.perf", {32'd0, perf_stall_cnt}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) applyStimulus();
      ibus.iresp_ok   = 1'b1;
      ibus.iresp_inst = 32'h1000_0013 + 32'(i);
      #1;
      checkOutput($sformatf("t1.addr%0d", i), ibus.ireq_addr, 64'h8000_0000 + 64'(4 * i));
      checkOutput($sformatf("t1.valid%0d", i), {63'd0, ibus.ireq_valid}, 64'd1);
      checkPayload($sformatf("t1.pay%0d", i), 1'b1, 32'h1000_0013 + 32'(i),
                   64'h8000_0000 + 64'(4 * i));
    end

    // 2: load-use on rs1 stalls IF/ID; rd=x0 does not; rs2 path also detected
    applyStimulus();
    ibus.iresp_ok = 1'b0;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    checkOutput("t2.en_if_id", {63'd0, en_if_id}, 64'd0);
    checkOutput("t2.en_id_ex", {63'd0, en_id_ex}, 64'd1);
    checkOutput("t2.bubble_id_ex", {63'd0, bubble_id_ex}, 64'd1);
    checkOutput("t2.flush", {63'd0, flush_if_id}, 64'd0);
    applyStimulus();
    ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    checkOutput("t2.x0.en_if_id", {63'd0, en_if_id}, 64'd1);
    checkOutput("t2.x0.bubble", {63'd0, bubble_id_ex}, 64'd0);
    checkOutput("t2.perf", {32'd0, perf_stall_cnt}, 64'd1);
    applyStimulus();
    ex_rd = 5'd9; id_use_rs1 = 1'b0; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    #1;
    checkOutput("t2.rs2.en_if_id", {63'd0, en_if_id}, 64'd0);
    applyStimulus();
    clearHazards();
    #1;
    checkOutput("t2.perf2", {32'd0, perf_stall_cnt}, 64'd2);
    checkOutput("t2.addr", ibus.ireq_addr, 64'h8000_000C);

    // 3: redirect while fetch outstanding -> F_KILL drops old response
    ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 64'h8000_0103;
    #1;
    checkOutput("t3.flush", {63'd0, flush_if_id}, 64'd1);
    checkOutput("t3.bubble_id_ex", {63'd0, bubble_id_ex}, 64'd1);
    checkOutput("t3.en_if_id", {63'd0, en_if_id}, 64'd1);
    applyStimulus();
    clearHazards();
    ibus.iresp_ok = 1'b1; ibus.iresp_inst = 32'hDEAD_BEEF;
    #1;
    checkOutput("t3.kill.addr", ibus.ireq_addr, 64'h8000_000C);
    checkOutput("t3.kill.valid", {63'd0, ibus.ireq_valid}, 64'd1);
    checkOutput("t3.kill.sig", {63'd0, if_id_next.inst_signal}, 64'd0);
    applyStimulus();
    ibus.iresp_inst = 32'h2000_0013;
    #1;
    checkOutput("t3.new.addr", ibus.ireq_addr, 64'h8000_0100);
    checkPayload("t3.new", 1'b1, 32'h2000_0013, 64'h8000_0100);

    // 4: data-bus stall for 3 cycles; fetch lands in hold buffer
    applyStimulus();
    ibus.iresp_ok = 1'b0; dreq_valid = 1'b1; dresp_ok = 1'b0;
    #1;
    checkOutput("t4.c1.en", {61'd0, en_if_id, en_id_ex, en_ex_mem}, 64'd0);
    checkOutput("t4.c1.bmw", {63'd0, bubble_mem_wb}, 64'd1);
    applyStimulus();
    ibus.iresp_ok = 1'b1; ibus.iresp_inst = 32'h3000_0013;
    #1;
    checkOutput("t4.c2.addr", ibus.ireq_addr, 64'h8000_0104);
    checkOutput("t4.c2.sig", {63'd0, if_id_next.inst_signal}, 64'd0);
    checkOutput("t4.c2.bmw", {63'd0, bubble_mem_wb}, 64'd1);
    applyStimulus();
    ibus.iresp_ok = 1'b0;
    #1;
    checkOutput("t4.c3.ireq_valid", {63'd0, ibus.ireq_valid}, 64'd0);
    checkOutput("t4.c3.en_if_id", {63'd0, en_if_id}, 64'd0);
    applyStimulus();
    dresp_ok = 1'b1;
    #1;
    checkOutput("t4.rel.en", {61'd0, en_if_id, en_id_ex, en_ex_mem}, 64'd7);
    checkOutput("t4.rel.bmw", {63'd0, bubble_mem_wb}, 64'd0);
    checkPayload("t4.rel", 1'b1, 32'h3000_0013, 64'h8000_0104);
    checkOutput("t4.perf", {32'd0, perf_stall_cnt}, 64'd5);

    // 5: redirect masked by mem stall, then taken once the data bus responds
    applyStimulus();
    dreq_valid = 1'b1; dresp_ok = 1'b0;
    ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 64'h8000_0200;
    ibus.iresp_ok = 1'b1; ibus.iresp_inst = 32'h4000_0013;
    #1;
    checkOutput("t5.masked.flush", {63'd0, flush_if_id}, 64'd0);
    checkOutput("t5.masked.en", {63'd0, en_if_id}, 64'd0);
    checkOutput("t5.masked.addr", ibus.ireq_addr, 64'h8000_0108);
    applyStimulus();
    dresp_ok = 1'b1; ibus.iresp_ok = 1'b0;
    #1;
    checkOutput("t5.taken.flush", {63'd0, flush_if_id}, 64'd1);
    checkOutput("t5.taken.bubble", {63'd0, bubble_id_ex}, 64'd1);
    checkOutput("t5.taken.sig", {63'd0, if_id_next.inst_signal}, 64'd0);
    checkOutput("t5.taken.ireq_valid", {63'd0, ibus.ireq_valid}, 64'd0);
    applyStimulus();
    clearHazards();
    #1;
    checkOutput("t5.addr", ibus.ireq_addr, 64'h8000_0200);
    checkOutput("t5.valid", {63'd0, ibus.ireq_valid}, 64'd1);
    checkOutput("t5.perf", {32'd0, perf_stall_cnt}, 64'd6);

    // 7: redirect with same-cycle response, then pc wraps past 2^64
    ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 64'hFFFF_FFFF_FFFF_FFFE;
    ibus.iresp_ok = 1'b1; ibus.iresp_inst = 32'h5000_0013;
    #1;
    checkOutput("t7.drop.sig", {63'd0, if_id_next.inst_signal}, 64'd0);
    applyStimulus();
    clearHazards();
    ibus.iresp_inst = 32'h6000_0013;
    #1;
    checkPayload("t7.top", 1'b1, 32'h6000_0013, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus();
    ibus.iresp_ok = 1'b0;
    #1;
    checkOutput("t7.wrap.addr", ibus.ireq_addr, 64'h0);

    // 6: reset asserted mid F_KILL takes effect immediately
    ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 64'h8000_0300;
    applyStimulus();
    clearHazards();
    #1;
    checkOutput("t6.kill.valid", {63'd0, ibus.ireq_valid}, 64'd1);
    checkOutput("t6.kill.addr", ibus.ireq_addr, 64'h0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6.rst.ireq_valid", {63'd0, ibus.ireq_valid}, 64'd0);
    checkOutput("t6.rst.en_if_id", {63'd0, en_if_id}, 64'd0);
    checkOutput("t6.rst.bubble_id_ex", {63'd0, bubble_id_ex}, 64'd1);
    checkOutput("t6.rst.perf", {32'd0, perf_stall_cnt}, 64'd0);
    @(posedge clk);
    applyStimulus();
    rst_n = 1'b1;
    #1;
    checkOutput("t6.rel.addr", ibus.ireq_addr, 64'h8000_0000);
    checkOutput("t6.rel.valid", {63'd0, ibus.ireq_valid}, 64'd1);
    checkOutput("t6.rel.perf", {32'd0, perf_stall_cnt}, 64'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
